// File: rtl/pad_ctrl.sv
// Sequencing controller for the message-padding datapath: loads message words, appends
// the pad word, zero fill and 64-bit bit length, and hands each 16-word block downstream.
//
// state | meaning
// IDLE  | clear index counter and length register, one cycle per message
// LOAD  | accept message words into the block
// PAD   | write the 0x80000000 pad word
// ZERO  | write zero fill words
// HI    | write length[63:32] at word 14
// LO    | write length[31:0] at word 15
// EMIT  | block complete, wait for blk_ack
// DONE  | one-cycle message-done pulse
module pad_ctrl (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       pkt_vld,
    input  logic       pkt_last,
    output logic       pkt_rdy,
    input  logic [3:0] ldx,
    input  logic       blk_ack,
    output logic       blk_vld,
    output logic       msg_done,
    output logic       st_pkt,
    output logic       c_up,
    output logic       inc_mgln,
    output logic       pad_pkt,
    output logic       zero_pkt,
    output logic       hi_mgln,
    output logic       lo_mgln,
    output logic       clr
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PAD, S_ZERO, S_HI, S_LO, S_EMIT, S_DONE
    } state_t;

    state_t state;
    state_t ret;
    logic   fin;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state <= S_IDLE;
            ret   <= S_LOAD;
            fin   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_LOAD;
                S_LOAD: begin
                    if (pkt_vld) begin
                        if (ldx == 4'd15) begin
                            state <= S_EMIT;
                            ret   <= pkt_last ? S_PAD : S_LOAD;
                        end else if (pkt_last) begin
                            state <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    case (ldx)
                        4'd13:   state <= S_HI;
                        4'd15: begin
                            state <= S_EMIT;
                            ret   <= S_ZERO;
                        end
                        default: state <= S_ZERO;
                    endcase
                end
                S_ZERO: begin
                    if (ldx == 4'd13) begin
                        state <= S_HI;
                    end else if (ldx == 4'd15) begin
                        state <= S_EMIT;
                        ret   <= S_ZERO;
                    end
                end
                S_HI: state <= S_LO;
                S_LO: begin
                    state <= S_EMIT;
                    fin   <= 1'b1;
                end
                S_EMIT: begin
                    if (blk_ack) state <= fin ? S_DONE : ret;
                end
                S_DONE: begin
                    fin   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state so strobes line up with the accepting cycle;
    // reset forces everything low, including the IDLE clear.
    always_comb begin
        pkt_rdy  = 1'b0;
        blk_vld  = 1'b0;
        msg_done = 1'b0;
        st_pkt   = 1'b0;
        c_up     = 1'b0;
        inc_mgln = 1'b0;
        pad_pkt  = 1'b0;
        zero_pkt = 1'b0;
        hi_mgln  = 1'b0;
        lo_mgln  = 1'b0;
        clr      = 1'b0;
        if (!rst_b) begin
            case (state)
                S_IDLE: clr = 1'b1;
                S_LOAD: begin
                    pkt_rdy  = 1'b1;
                    st_pkt   = pkt_vld;
                    c_up     = pkt_vld;
                    inc_mgln = pkt_vld;
                end
                S_PAD: begin
                    st_pkt  = 1'b1;
                    pad_pkt = 1'b1;
                    c_up    = 1'b1;
                end
                S_ZERO: begin
                    st_pkt   = 1'b1;
                    zero_pkt = 1'b1;
                    c_up     = 1'b1;
                end
                S_HI: begin
                    st_pkt  = 1'b1;
                    hi_mgln = 1'b1;
                    c_up    = 1'b1;
                end
                S_LO: begin
                    st_pkt  = 1'b1;
                    lo_mgln = 1'b1;
                    c_up    = 1'b1;
                end
                S_EMIT:  blk_vld  = 1'b1;
                S_DONE:  msg_done = 1'b1;
                default: clr      = 1'b0;
            endcase
        end
    end

endmodule
